stage_id: RTL and testbench

STAGE_ID -- requirements
Module: stage_ID

---
 rtl/stage_id.sv | 137 +++++++++++++
 tb/tb_stage_id.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stage_id.sv
// rtl/stage_id.sv - instruction decode stage: IF/ID latch, register file, load-use stall, immediate gen
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module stage_id #(
  parameter int addr_width = `MEM_ADDR_WIDTH,
  parameter int word_width = `WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] inst_in,
  input  logic [addr_width-1:0] pc_in,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd,
  input  logic [word_width-1:0] wb_data,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_rd,
  output logic                  pc_en,
  output logic                  id_valid,
  output logic [addr_width-1:0] pc_out,
  output logic [6:0]            opcode,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [2:0]            funct3,
  output logic                  funct7b5,
  output logic [word_width-1:0] rs1_data,
  output logic [word_width-1:0] rs2_data,
  output logic [word_width-1:0] imm,
  output logic                  illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [word_width-1:0] NOP = word_width'(32'h0000_0013);

  logic [word_width-1:0] inst_q, inst_d;
  logic [addr_width-1:0] pc_q, pc_d;
  logic [word_width-1:0] regs_q [32];
  logic [word_width-1:0] regs_d [32];
  logic                  rs1_used, rs2_used, stall, legal;
  logic [31:0]           imm32;

  assign opcode   = inst_q[6:0];
  assign rd       = inst_q[11:7];
  assign funct3   = inst_q[14:12];
  assign rs1      = inst_q[19:15];
  assign rs2      = inst_q[24:20];
  assign funct7b5 = inst_q[30];
  assign pc_out   = pc_q;

  // Stall is a function of the latched instruction, so a reset that reloads the NOP releases it at once.
  always_comb begin
    rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    rs2_used = (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
    stall    = ex_mem_read && (ex_rd != 5'd0) && !flush &&
               (((ex_rd == rs1) && rs1_used) || ((ex_rd == rs2) && rs2_used));
    pc_en    = !stall;
    id_valid = !stall;
  end

  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    if (flush) begin
      inst_d = NOP;
      pc_d   = pc_in;
    end else if (!stall) begin
      inst_d = inst_in;
      pc_d   = pc_in;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd != 5'd0)) regs_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q <= NOP;
      pc_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

  // Write-back in the same cycle as the read is forwarded; x0 never matches.
  always_comb begin
    rs1_data = regs_q[rs1];
    rs2_data = regs_q[rs2];
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_data = wb_data;
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_data = wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  always_comb begin
    imm32 = 32'd0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{inst_q[31]}}, inst_q[31:20]};
      OP_STORE:  imm32 = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      OP_BRANCH: imm32 = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {inst_q[31:12], 12'd0};
      OP_JAL:    imm32 = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      default:   imm32 = 32'd0;
    endcase
    imm = word_width'(signed'(imm32));
  end

  always_comb begin
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
      OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    illegal = id_valid && !legal;
  end

endmodule

// File: tb/tb_stage_id.sv
// tb/tb_stage_id.sv - self-checking bench for stage_id
module tb_stage_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_in, pc_in, wb_data;
  logic        flush, wb_en, ex_mem_read;
  logic [4:0]  wb_rd, ex_rd;
  logic        pc_en, id_valid, funct7b5, illegal;
  logic [31:0] pc_out, rs1_data, rs2_data, imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic        illegal;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [31:0] ADD_5_2_4 = 32'h0041_02B3;

  stage_id #(.addr_width(32), .word_width(32)) dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .pc_in(pc_in), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .pc_en(pc_en), .id_valid(id_valid), .pc_out(pc_out), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (pc_en !== 1'b1) begin n_errors++; $display("FAIL reset_pc_en got %0b want 1", pc_en); end
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL reset_id_valid got %0b want 1", id_valid); end
    n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL reset_illegal got %0b want 0", illegal); end
    n_checks++; if (imm !== 32'd0) begin n_errors++; $display("FAIL reset_imm got %h want 0", imm); end
    n_checks++; if (opcode !== 7'h13) begin n_errors++; $display("FAIL reset_opcode got %h want 13", opcode); end
    n_checks++; if (pc_out !== 32'd0) begin n_errors++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
    n_checks++; if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got %h/%h want 0/0", rs1_data, rs2_data); end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    inst_in = 32'h0050_0093; pc_in = 32'h10;
    tick();
    n_checks++; if (opcode !== 7'b0010011) begin n_errors++; $display("FAIL addi_opcode got %b want 0010011", opcode); end
    n_checks++; if (rd !== 5'd1) begin n_errors++; $display("FAIL addi_rd got %0d want 1", rd); end
    n_checks++; if (imm !== 32'd5) begin n_errors++; $display("FAIL addi_imm got %h want 5", imm); end
    n_checks++; if (pc_out !== 32'h10) begin n_errors++; $display("FAIL addi_pc_out got %h want 10", pc_out); end
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL addi_id_valid got %0b want 1", id_valid); end
    ex_mem_read = 1'b1; ex_rd = 5'd0; #1;
    n_checks++; if (pc_en !== 1'b1) begin n_errors++; $display("FAIL ex_rd0_no_stall pc_en got %0b want 1", pc_en); end
    ex_mem_read = 1'b0;
  endtask

  task automatic test_regfile();
    inst_in = 32'h0001_8313; pc_in = 32'h14;
    tick();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF; #1;
    n_checks++; if (rs1_data !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL bypass_rs1 got %h want deadbeef", rs1_data); end
    tick();
    wb_en = 1'b0; #1;
    n_checks++; if (rs1_data !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL regread_rs1 got %h want deadbeef", rs1_data); end
    inst_in = 32'h0000_0313; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
    tick();
    n_checks++; if (rs1_data !== 32'd0) begin n_errors++; $display("FAIL x0_read got %h want 0", rs1_data); end
    inst_in = ADD_5_2_4; wb_en = 1'b0;
    tick();
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hCAFE_F00D; #1;
    n_checks++; if (rs2_data !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL bypass_rs2 got %h want cafef00d", rs2_data); end
    tick();
    wb_en = 1'b0; #1;
    n_checks++; if (rs2_data !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL regread_rs2 got %h want cafef00d", rs2_data); end
    n_checks++; if (rs1_data !== 32'd0) begin n_errors++; $display("FAIL unwritten_x2 got %h want 0", rs1_data); end
  endtask

  task automatic test_stall();
    inst_in = ADD_5_2_4; pc_in = 32'h20;
    tick();
    inst_in = 32'h0050_0093; pc_in = 32'h24; ex_mem_read = 1'b1; ex_rd = 5'd4; #1;
    n_checks++; if (pc_en !== 1'b0) begin n_errors++; $display("FAIL stall_pc_en got %0b want 0", pc_en); end
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL stall_id_valid got %0b want 0", id_valid); end
    tick();
    n_checks++; if (pc_out !== 32'h20 || opcode !== 7'h33) begin n_errors++; $display("FAIL stall_hold got pc %h op %h want 20/33", pc_out, opcode); end
    ex_mem_read = 1'b0; #1;
    n_checks++; if (pc_en !== 1'b1 || id_valid !== 1'b1) begin n_errors++; $display("FAIL stall_release got %0b/%0b want 1/1", pc_en, id_valid); end
    tick();
    n_checks++; if (pc_out !== 32'h24) begin n_errors++; $display("FAIL stall_advance got %h want 24", pc_out); end
    inst_in = 32'h1234_50B7; pc_in = 32'h28;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd8; #1;
    n_checks++; if (pc_en !== 1'b1) begin n_errors++; $display("FAIL lui_no_rs1_stall got %0b want 1", pc_en); end
    ex_mem_read = 1'b0;
  endtask

  task automatic test_flush();
    inst_in = ADD_5_2_4; pc_in = 32'h30;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd4; flush = 1'b1; pc_in = 32'h40; inst_in = 32'h0050_0093; #1;
    n_checks++; if (pc_en !== 1'b1 || id_valid !== 1'b1) begin n_errors++; $display("FAIL flush_prio got %0b/%0b want 1/1", pc_en, id_valid); end
    tick();
    flush = 1'b0; ex_mem_read = 1'b0;
    n_checks++; if (opcode !== 7'h13 || rd !== 5'd0 || imm !== 32'd0) begin n_errors++; $display("FAIL flush_nop got op %h rd %0d imm %h want 13/0/0", opcode, rd, imm); end
    n_checks++; if (pc_out !== 32'h40) begin n_errors++; $display("FAIL flush_pc got %h want 40", pc_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [9];
    logic [31:0] imms  [9];
    logic        ills  [9];
    exp_t        e;
    insts = '{32'hFE00_0EE3, 32'h0080_006F, 32'h1234_50B7, 32'hFE20_AC23, 32'hFFFF_F017,
              32'hFFF0_2083, ADD_5_2_4, 32'h0000_007F, 32'h0000_000F};
    imms  = '{32'hFFFF_FFFC, 32'h8, 32'h1234_5000, 32'hFFFF_FFF8, 32'hFFFF_F000,
              32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    ills  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      inst_in = insts[i]; pc_in = 32'h100 + 32'(i * 4);
      e.imm = imms[i]; e.opcode = insts[i][6:0]; e.illegal = ills[i];
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++; if (imm !== e.imm) begin n_errors++; $display("FAIL b2b_imm[%0d] got %h want %h", i, imm, e.imm); end
      n_checks++; if (opcode !== e.opcode) begin n_errors++; $display("FAIL b2b_opcode[%0d] got %h want %h", i, opcode, e.opcode); end
      n_checks++; if (illegal !== e.illegal) begin n_errors++; $display("FAIL b2b_illegal[%0d] got %0b want %0b", i, illegal, e.illegal); end
    end
  endtask

  task automatic test_reset_mid_stall();
    inst_in = ADD_5_2_4; pc_in = 32'h50;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd4; #1;
    n_checks++; if (pc_en !== 1'b0) begin n_errors++; $display("FAIL pre_reset_stall got %0b want 0", pc_en); end
    rst = 1'b1; #1;
    n_checks++; if (pc_en !== 1'b1 || id_valid !== 1'b1) begin n_errors++; $display("FAIL rst_stall_release got %0b/%0b want 1/1", pc_en, id_valid); end
    n_checks++; if (opcode !== 7'h13 || pc_out !== 32'd0 || imm !== 32'd0 || illegal !== 1'b0) begin n_errors++; $display("FAIL rst_latch got op %h pc %h imm %h ill %0b", opcode, pc_out, imm, illegal); end
    tick();
    rst = 1'b0; ex_mem_read = 1'b0;
    tick();
    n_checks++; if (rs2_data !== 32'd0) begin n_errors++; $display("FAIL rst_regs_cleared got %h want 0", rs2_data); end
  endtask

  initial begin
    rst = 1'b1; inst_in = 32'd0; pc_in = 32'd0; flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0;
    wb_data = 32'd0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    test_reset();
    test_decode();
    test_regfile();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
